ultra_range_parser: RTL
=======================

Name: ultra_range_parser

Overview:
Parametrised hardware parser for ASCII range frames from the ultrasonic sensor (header char, NDIGITS decimal digits, terminator). It sits between the uart_rx FIFO read side and the display/host logic. It replaces firmware-driven digit latching with validated, atomically committed BCD and binary range outputs. It adds error detection, inter-byte timeout and error counting.

Parameters:
NDIGITS, 3, number of decimal digits per frame (1..5)
VAL_W, 10, width of binary range output; must satisfy 2^VAL_W > 10^NDIGITS-1
HDR_CHAR, 8'h52, frame header byte ('R')
TERM_CHAR, 8'h0D, frame terminator byte (CR)
TIMEOUT_CYC, 160000, max clk cycles between bytes inside a frame (~3 byte times at 9600 baud, 50 MHz)
TO_W, 18, timeout counter width; must hold TIMEOUT_CYC

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_data  input  8  received byte
rx_valid  input  1  one-cycle strobe, rx_data valid this cycle
digits  output  4*NDIGITS  committed BCD range; most significant digit in top nibble
range_bin  output  VAL_W  committed binary range value
range_valid  output  1  one-cycle pulse on commit
frame_err  output  1  one-cycle pulse on any frame error
err_count  output  8  saturating frame error count
busy  output  1  high while in DIGITS or TERM state

Behaviour:
- One clock domain; reset is synchronous and active-high. All regs update on posedge clk.
- Reset values: digits=0, range_bin=0, range_valid=0, frame_err=0, err_count=0, busy=0, state=IDLE, shadow regs=0, digit count=0, timer=0.
- Reset mid-frame discards shadow contents; committed outputs go to 0.
- Internal state: shadow BCD shift reg, shadow binary accumulator, digit counter, timeout timer.
- FSM states:
  - IDLE: rx_valid & rx_data==HDR_CHAR -> DIGITS; clear shadow, counter, timer. All other bytes are ignored, with no error.
  - DIGITS: rx_valid & byte in 8'h30..8'h39 -> shift (byte-8'h30) into the shadow LSB nibble; acc <= acc*10 + d, computed at VAL_W+4 bits and truncated to VAL_W; counter++. When the counter reaches NDIGITS -> TERM.
  - TERM: rx_valid & rx_data==TERM_CHAR -> commit shadow to digits/range_bin; range_valid=1 for one cycle; -> IDLE.
- Commit latency: outputs and range_valid update on the clock edge after the cycle in which the TERM_CHAR strobe is present. Outputs hold their value between commits; partial frames never alter them.
- Errors (each pulses frame_err for 1 cycle and increments err_count, saturating at 255):
  - Non-digit byte in DIGITS -> IDLE.
  - Byte other than TERM_CHAR in TERM -> IDLE.
  - HDR_CHAR received in DIGITS or TERM -> DIGITS (resync); shadow and counter are cleared and the byte counts as a new header.
  - Timer reaches TIMEOUT_CYC while busy -> IDLE.
- Timer behaviour: it resets on every accepted rx_valid and counts only while busy. If rx_valid and timeout expiry occur in the same cycle, the byte wins: it is processed, the timer clears and no timeout error is raised.
- busy is high in DIGITS and TERM, combinational from state.
- TERM_CHAR arriving in DIGITS (short frame) is a non-digit error.

Test Plan:
- Bytes 52 31 32 33 0D at 1 byte/10 cycles -> range_valid pulse 1 cycle after 0D; digits=12'h123; range_bin=123; err_count=0.
- Frame "R999\r", then "R007\r" -> range_bin=999, then 7; digits=12'h007; two range_valid pulses.
- "R1A3\r" -> frame_err on 'A'; state IDLE; outputs keep previous value; err_count=1. The trailing '3', 0D are ignored with no extra error.
- "R12R456\r" -> one frame_err at the second 'R'; commit digits=12'h456, range_bin=456.
- "R12" then idle for TIMEOUT_CYC cycles -> frame_err exactly at expiry, busy drops. Separately, a byte landing on the expiry cycle -> no error.
- 300 bad frames -> err_count saturates at 255. Reset asserted mid-frame -> all outputs 0, next valid frame commits normally.

Source files
------------

// File: rtl/ultra_range_parser.sv
// Parser for ASCII ultrasonic range frames ("R" + NDIGITS digits + CR).
// Builds BCD and binary values in shadow registers and commits them together on the terminator.
module ultra_range_parser #(
   parameter int          NDIGITS     = 3,
   parameter int          VAL_W       = 10,
   parameter logic [7:0]  HDR_CHAR    = 8'h52,
   parameter logic [7:0]  TERM_CHAR   = 8'h0D,
   parameter int          TIMEOUT_CYC = 160000,
   parameter int          TO_W        = 18
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic [4*NDIGITS-1:0]   digits,
   output logic [VAL_W-1:0]       range_bin,
   output logic                   range_valid,
   output logic                   frame_err,
   output logic [7:0]             err_count,
   output logic                   busy
);

   // state  | meaning
   // IDLE   | waiting for a header byte, everything else ignored
   // DIGITS | collecting decimal digits into the shadow registers
   // TERM   | all digits seen, waiting for the terminator to commit

   localparam int BW    = 4*NDIGITS;
   localparam int CNT_W = $clog2(NDIGITS+1);

   typedef enum logic [1:0] {S_IDLE, S_DIGITS, S_TERM} state_t;

   state_t             state;
   logic [BW-1:0]      shadow_bcd;
   logic [VAL_W-1:0]   shadow_acc;
   logic [CNT_W-1:0]   digit_cnt;
   logic [TO_W-1:0]    timer;

   logic               is_digit;
   logic               is_hdr;
   logic               is_term;
   logic               expired;
   logic               err_now;
   logic [3:0]         digit_val;
   logic [BW-1:0]      bcd_next;
   logic [VAL_W-1:0]   acc_next;

   assign busy      = (state == S_DIGITS) || (state == S_TERM);
   assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_hdr    = (rx_data == HDR_CHAR);
   assign is_term   = (rx_data == TERM_CHAR);
   // For '0'..'9' the low nibble is exactly the digit value.
   assign digit_val = rx_data[3:0];
   assign bcd_next  = (shadow_bcd << 4) | BW'(digit_val);
   // Modular arithmetic: computing at VAL_W bits gives the same low bits as a wider sum truncated.
   assign acc_next  = shadow_acc * VAL_W'(10) + VAL_W'(digit_val);
   assign expired   = busy && (timer == TO_W'(TIMEOUT_CYC));

   always_comb begin
      err_now = 1'b0;
      if (state == S_DIGITS && rx_valid && !is_digit)
         err_now = 1'b1;
      if (state == S_TERM && rx_valid && !is_term)
         err_now = 1'b1;
      if (expired && !rx_valid)
         err_now = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         shadow_bcd  <= '0;
         shadow_acc  <= '0;
         digit_cnt   <= '0;
         timer       <= '0;
         digits      <= '0;
         range_bin   <= '0;
         range_valid <= 1'b0;
         frame_err   <= 1'b0;
         err_count   <= '0;
      end else begin
         range_valid <= 1'b0;
         frame_err   <= 1'b0;
         if (err_now) begin
            frame_err <= 1'b1;
            if (err_count != 8'hFF)
               err_count <= err_count + 8'd1;
         end

         case (state)
            S_IDLE: begin
               timer <= '0;
               if (rx_valid && is_hdr) begin
                  state      <= S_DIGITS;
                  shadow_bcd <= '0;
                  shadow_acc <= '0;
                  digit_cnt  <= '0;
               end
            end

            S_DIGITS: begin
               if (rx_valid) begin
                  timer <= '0;
                  if (is_digit) begin
                     shadow_bcd <= bcd_next;
                     shadow_acc <= acc_next;
                     digit_cnt  <= digit_cnt + CNT_W'(1);
                     if (digit_cnt == CNT_W'(NDIGITS-1))
                        state <= S_TERM;
                  end else if (is_hdr) begin
                     shadow_bcd <= '0;
                     shadow_acc <= '0;
                     digit_cnt  <= '0;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (expired) begin
                  state <= S_IDLE;
                  timer <= '0;
               end else begin
                  timer <= timer + TO_W'(1);
               end
            end

            S_TERM: begin
               if (rx_valid) begin
                  timer <= '0;
                  if (is_term) begin
                     digits      <= shadow_bcd;
                     range_bin   <= shadow_acc;
                     range_valid <= 1'b1;
                     state       <= S_IDLE;
                  end else if (is_hdr) begin
                     // Header inside a frame restarts collection with this byte as the new header.
                     shadow_bcd <= '0;
                     shadow_acc <= '0;
                     digit_cnt  <= '0;
                     state      <= S_DIGITS;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (expired) begin
                  state <= S_IDLE;
                  timer <= '0;
               end else begin
                  timer <= timer + TO_W'(1);
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
